// File: rtl/key_pkg.sv
// Shared types and elaboration-time helpers for the key debounce bank.
package key_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_HELD     = 2'd1,
        ST_REPEAT   = 2'd2
    } key_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Pin level seen when the key is not pressed.
    function automatic logic key_released_lvl(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, stability counter, hold/repeat FSM.
// Latency: pin to o_key/o_press_pulse = 2 + STABLE_CYCLES clocks. No backpressure; strobes are 1 cycle.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES = 196608,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_key,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_pulse
);

    localparam logic REL_LVL = key_released_lvl(ACTIVE_LOW);
    localparam int   SW      = cnt_width(STABLE_CYCLES);
    localparam int   HW      = cnt_width(max2(LONG_CYCLES, REPEAT_CYCLES));

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST    = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_key;
    logic          r_pressed;
    logic [SW-1:0] r_stab_cnt;
    logic          r_press_pulse;
    logic          r_release_pulse;

    key_state_e    r_state;
    logic [HW-1:0] r_hold_cnt;
    logic          r_long_pulse;

    logic w_differ;
    logic w_accept;
    logic w_acc_press;
    logic w_acc_release;

    assign w_differ      = (r_sync2 != r_key);
    assign w_accept      = w_differ && (r_stab_cnt == STABLE_LAST);
    assign w_acc_press   = w_accept && (r_sync2 != REL_LVL);
    assign w_acc_release = w_accept && (r_sync2 == REL_LVL);

    // Sync flops reset to the released level so reset release looks like a fresh edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1         <= REL_LVL;
            r_sync2         <= REL_LVL;
            r_key           <= REL_LVL;
            r_pressed       <= 1'b0;
            r_stab_cnt      <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_sync1         <= i_key;
            r_sync2         <= r_sync1;
            r_press_pulse   <= w_acc_press;
            r_release_pulse <= w_acc_release;
            if (!w_differ) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt == STABLE_LAST) begin
                r_key      <= r_sync2;
                r_pressed  <= (r_sync2 != REL_LVL);
                r_stab_cnt <= '0;
            end else begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end
        end
    end

    // Release is checked first so it beats a long/repeat strobe due on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RELEASED;
            r_hold_cnt   <= '0;
            r_long_pulse <= 1'b0;
        end else begin
            r_long_pulse <= 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    r_hold_cnt <= '0;
                    if (w_acc_press) begin
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (w_acc_release) begin
                        r_state    <= ST_RELEASED;
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == LONG_LAST) begin
                        r_state      <= ST_REPEAT;
                        r_long_pulse <= 1'b1;
                        r_hold_cnt   <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (w_acc_release) begin
                        r_state    <= ST_RELEASED;
                        r_hold_cnt <= '0;
                    end else if (REPEAT_CYCLES != 0) begin
                        if (r_hold_cnt == REP_LAST) begin
                            r_long_pulse <= 1'b1;
                            r_hold_cnt   <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_RELEASED;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign o_key           = r_key;
    assign o_pressed       = r_pressed;
    assign o_press_pulse   = r_press_pulse;
    assign o_release_pulse = r_release_pulse;
    assign o_long_pulse    = r_long_pulse;

endmodule

// File: rtl/key_debounce_bank.sv
// N independent debounced key channels with press/release/long-press strobes.
// Latency: 2 + STABLE_CYCLES clocks pin to level/strobe. No backpressure; all strobes 1 cycle.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int N_KEYS        = 8,
    parameter int STABLE_CYCLES = 196608,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_out,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .i_clk           (clk),
            .i_rst           (rst),
            .i_key           (key_in[g]),
            .o_key           (key_out[g]),
            .o_pressed       (pressed[g]),
            .o_press_pulse   (press_pulse[g]),
            .o_release_pulse (release_pulse[g]),
            .o_long_pulse    (long_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank with 4 active-low keys and short timings.
module tb_key_debounce_bank;

    logic       clk;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_out;
    logic [3:0] pressed;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;

    int n_tests;
    int n_fail;

    key_debounce_bank #(
        .N_KEYS        (4),
        .STABLE_CYCLES (8),
        .LONG_CYCLES   (32),
        .REPEAT_CYCLES (16),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .key_out       (key_out),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        key_in = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (key_out !== 4'hF) begin n_fail++; $display("FAIL reset_key_out got %b want %b", key_out, 4'hF); end
        n_tests++;
        if (pressed !== 4'h0) begin n_fail++; $display("FAIL reset_pressed got %b want %b", pressed, 4'h0); end
        n_tests++;
        if ((press_pulse | release_pulse | long_pulse) !== 4'h0) begin
            n_fail++; $display("FAIL reset_pulses got %b/%b/%b want 0", press_pulse, release_pulse, long_pulse);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press;
        logic [3:0] exp_p;
        key_in[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (press_pulse !== exp_p) begin n_fail++; $display("FAIL clean_press_pulse k=%0d got %b want %b", k, press_pulse, exp_p); end
            n_tests++;
            if (key_out[0] !== (k < 10)) begin n_fail++; $display("FAIL clean_key_out k=%0d got %b want %b", k, key_out[0], (k < 10)); end
            n_tests++;
            if (pressed !== ((k >= 10) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL clean_pressed k=%0d got %b", k, pressed); end
        end
        key_in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b0001 : 4'b0000;
            n_tests++;
            if (release_pulse !== exp_p) begin n_fail++; $display("FAIL clean_release_pulse k=%0d got %b want %b", k, release_pulse, exp_p); end
            n_tests++;
            if (long_pulse !== 4'b0000) begin n_fail++; $display("FAIL clean_no_long k=%0d got %b want 0000", k, long_pulse); end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] exp_p;
        for (int i = 0; i < 40; i++) begin
            key_in[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            n_tests++;
            if ((press_pulse | release_pulse) !== 4'b0000) begin
                n_fail++; $display("FAIL bounce_quiet i=%0d got %b/%b want 0", i, press_pulse, release_pulse);
            end
        end
        key_in[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b0010 : 4'b0000;
            n_tests++;
            if (press_pulse !== exp_p) begin n_fail++; $display("FAIL bounce_settle_press k=%0d got %b want %b", k, press_pulse, exp_p); end
        end
        key_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b0010 : 4'b0000;
            n_tests++;
            if (release_pulse !== exp_p) begin n_fail++; $display("FAIL bounce_release k=%0d got %b want %b", k, release_pulse, exp_p); end
        end
    endtask

    // Press accepted at k=10, long at 42 then every 16; release accepted at 110 cancels 122.
    task automatic test_long_repeat;
        logic [3:0] exp_l;
        logic [3:0] exp_r;
        key_in[2] = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            tick();
            exp_l = (k >= 42 && k < 110 && ((k - 42) % 16) == 0) ? 4'b0100 : 4'b0000;
            exp_r = (k == 110) ? 4'b0100 : 4'b0000;
            n_tests++;
            if (long_pulse !== exp_l) begin n_fail++; $display("FAIL long_pulse k=%0d got %b want %b", k, long_pulse, exp_l); end
            n_tests++;
            if (release_pulse !== exp_r) begin n_fail++; $display("FAIL long_release k=%0d got %b want %b", k, release_pulse, exp_r); end
            if (k == 100) key_in[2] = 1'b1;
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] exp_p;
        key_in = 4'b0110;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b1001 : 4'b0000;
            n_tests++;
            if (press_pulse !== exp_p) begin n_fail++; $display("FAIL simul_press k=%0d got %b want %b", k, press_pulse, exp_p); end
        end
        key_in = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b1001 : 4'b0000;
            n_tests++;
            if (release_pulse !== exp_p) begin n_fail++; $display("FAIL simul_release k=%0d got %b want %b", k, release_pulse, exp_p); end
        end
    endtask

    // ch2 enters REPEAT at 42; ch1 debounce count is 5 after edge 57; reset on edge 58 suppresses the repeat strobe.
    task automatic test_reset_mid_op;
        logic [3:0] exp_p;
        key_in[2] = 1'b0;
        for (int k = 1; k <= 57; k++) begin
            tick();
            exp_p = (k == 42) ? 4'b0100 : 4'b0000;
            n_tests++;
            if (long_pulse !== exp_p) begin n_fail++; $display("FAIL midrst_pre_long k=%0d got %b want %b", k, long_pulse, exp_p); end
            if (k == 50) key_in[1] = 1'b0;
        end
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            n_tests++;
            if (key_out !== 4'hF || pressed !== 4'h0) begin
                n_fail++; $display("FAIL midrst_levels k=%0d got %b/%b want 1111/0000", k, key_out, pressed);
            end
            n_tests++;
            if ((press_pulse | release_pulse | long_pulse) !== 4'h0) begin
                n_fail++; $display("FAIL midrst_pulses k=%0d got %b/%b/%b want 0", k, press_pulse, release_pulse, long_pulse);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b0110 : 4'b0000;
            n_tests++;
            if (press_pulse !== exp_p) begin n_fail++; $display("FAIL midrst_repress k=%0d got %b want %b", k, press_pulse, exp_p); end
            n_tests++;
            if ((release_pulse | long_pulse) !== 4'h0) begin
                n_fail++; $display("FAIL midrst_quiet k=%0d got %b/%b want 0", k, release_pulse, long_pulse);
            end
        end
        key_in = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_p = (k == 10) ? 4'b0110 : 4'b0000;
            n_tests++;
            if (release_pulse !== exp_p) begin n_fail++; $display("FAIL midrst_release k=%0d got %b want %b", k, release_pulse, exp_p); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        key_in  = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_simultaneous();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_bank.md
Name: key_debounce_bank

Overview:
- Parametrised multi-channel push-button conditioner; successor to the single-key debouncer used by the marquee/LED experiments.
- Synchronises N raw key inputs, debounces each independently, and produces the debounced level, one-cycle press/release strobes, and long-press / auto-repeat strobes.
- Sits between board pins and the mode/speed control FSMs of the LED system.

Parameters:
- N_KEYS, 8, number of independent key channels.
- STABLE_CYCLES, 196608, consecutive synchronised cycles a new level must hold before acceptance (>=2).
- LONG_CYCLES, 50000000, cycles pressed before the first long_pulse (> STABLE_CYCLES).
- REPEAT_CYCLES, 10000000, auto-repeat period after long_pulse; 0 disables repeat.
- ACTIVE_LOW, 1, 1 = key pulls input to 0 when pressed; 0 = active-high keys.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_in  in  N_KEYS  raw asynchronous key pins.
- key_out  out  N_KEYS  debounced level, raw pin polarity.
- pressed  out  N_KEYS  debounced level, 1 = pressed regardless of ACTIVE_LOW.
- press_pulse  out  N_KEYS  1-cycle strobe on accepted press.
- release_pulse  out  N_KEYS  1-cycle strobe on accepted release.
- long_pulse  out  N_KEYS  1-cycle strobe at long-press and on each auto-repeat.

Behaviour:
- One clock, reset synchronous active-high; all state changes on posedge clk.
- Reset values: sync flops, key_out = released level (all 1 if ACTIVE_LOW else all 0); pressed, press_pulse, release_pulse, long_pulse = 0; all counters 0.
- Sync: 2-flop synchroniser per bit; s = second stage.
- Stability counter (width clog2(STABLE_CYCLES)): if s == key_out, cnt <= 0; else if cnt == STABLE_CYCLES-1, key_out <= s, cnt <= 0; else cnt <= cnt+1.
- Any glitch back to key_out level clears cnt; acceptance requires STABLE_CYCLES consecutive differing samples.
- Latency: pin change to key_out change = 2 (sync) + STABLE_CYCLES cycles.
- press_pulse/release_pulse are registered and asserted in the same cycle key_out updates; high for exactly 1 cycle.
- Per-channel FSM: RELEASED -> (accepted press) HELD -> (hold_cnt == LONG_CYCLES-1) REPEAT; any accepted release -> RELEASED from any state.
- hold_cnt (width clog2(max(LONG_CYCLES,REPEAT_CYCLES))): cleared on entry to HELD and on release; increments while HELD/REPEAT.
- long_pulse fires when HELD reaches LONG_CYCLES-1 (i.e. LONG_CYCLES cycles after press_pulse); in REPEAT fires every REPEAT_CYCLES cycles and hold_cnt wraps to 0; REPEAT_CYCLES=0: stays in REPEAT, no further pulses, counter frozen.
- A release accepted on the same cycle hold_cnt would fire: release wins, no long_pulse.
- Channels are fully independent; simultaneous events on different channels all reported in the same cycle.
- rst asserted mid-debounce or mid-hold: everything returns to reset values next edge; no pulses emitted during or on exit of reset.
- Keys held at reset release: treated as new presses (reported after 2+STABLE_CYCLES).

Decomposition:
- Package key_pkg: clog2-based width helper, KEY_RELEASED_LVL(ACTIVE_LOW) constant function, per-channel FSM state enum (RELEASED, HELD, REPEAT).
- Sub-module key_debounce_ch: one channel (sync, stability counter, FSM, hold counter); top instantiates N_KEYS copies via generate and concatenates outputs.

Test Plan (N_KEYS=4, STABLE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=16, ACTIVE_LOW=1):
- Reset check: rst high 3 cycles -> key_out=4'b1111, pressed/pulses=0.
- Clean press ch0: key_in[0]=0 held -> press_pulse[0] high exactly 1 cycle, 10 cycles after the change; key_out[0]=0, pressed[0]=1 same cycle.
- Bounce: ch1 toggles every 3 cycles for 40 cycles then settles 0 -> no pulses during bounce; press_pulse[1] 10 cycles after final settle.
- Long press/repeat ch2: hold 100 cycles -> long_pulse[2] 32 cycles after press_pulse, then every 16 cycles; release -> release_pulse[2] and no further long_pulse.
- Simultaneous: ch0 and ch3 pressed same cycle -> press_pulse=4'b1001 in one cycle.
- Reset mid-operation: assert rst with cnt=5 on ch1 and ch2 in REPEAT -> all outputs reset values, no pulses; key still held after rst -> press reported 10 cycles later.
